// File: rtl/decoder_pkg.sv
// Shared constants, FSM state encoding and the binary-to-one-hot helper.
// Used by the bus interface, the FIFO wrapper and the display FSM.
package decoder_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned DWELL_W  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Binary code to one-hot word; used only on the registered load path.
    function automatic logic [ONEHOT_W-1:0] to_onehot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] oh;
        oh = '0;
        case (code)
            3'd0:    oh = 8'h01;
            3'd1:    oh = 8'h02;
            3'd2:    oh = 8'h04;
            3'd3:    oh = 8'h08;
            3'd4:    oh = 8'h10;
            3'd5:    oh = 8'h20;
            3'd6:    oh = 8'h40;
            default: oh = 8'h80;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/onehot_decoder_if.sv
// Producer/display bus of the one-hot decoder.
// master: producer/observer side (drives in_valid, in_code, en).
// slave : decoder side (drives in_ready, out, out_valid, busy, count).
interface onehot_decoder_if #(
    parameter int unsigned DEPTH = 4
);
    import decoder_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic                in_ready;
    logic [CODE_W-1:0]   in_code;
    logic                en;
    logic [ONEHOT_W-1:0] out;
    logic                out_valid;
    logic                busy;
    logic [CNT_W-1:0]    count;

    modport master (
        output in_valid, in_code, en,
        input  in_ready, out, out_valid, busy, count
    );

    modport slave (
        input  in_valid, in_code, en,
        output in_ready, out, out_valid, busy, count
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset.
// Ports: clk, rst, push/wdata (ignored when full), pop/rdata (ignored when
// empty, rdata is the current head), full, empty, count (occupancy).
module sync_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read behind a non-zero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/onehot_decoder.sv
// Queues 3-bit codes in a FIFO and shows each as a one-hot word for DWELL
// enabled cycles, back to back while codes are pending.
// Ports: clk, rst (sync, active-high), bus (slave): in_valid/in_ready/in_code
// input handshake, en display enable, out/out_valid display, busy, count.
module onehot_decoder
    import decoder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DWELL = 4
) (
    input logic              clk,
    input logic              rst,
    onehot_decoder_if.slave  bus
);

    state_e               state_q, state_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [ONEHOT_W-1:0]  out_q,   out_d;
    logic                 pop;
    logic [CODE_W-1:0]    head;
    logic                 fifo_full;
    logic                 fifo_empty;

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata (bus.in_code),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (bus.count)
    );

    // in_ready looks only at occupancy, so a full FIFO stalls even on a pop.
    assign bus.in_ready  = !fifo_full;
    // Disabling the display blanks it immediately without losing progress.
    assign bus.out       = bus.en ? out_q : '0;
    assign bus.out_valid = bus.en && (state_q == SHOW);
    assign bus.busy      = (state_q == SHOW) || !fifo_empty;

    // Next-state: load head on entry or on dwell expiry; en=0 freezes all.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        out_d   = out_q;
        pop     = 1'b0;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    out_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        out_d   = to_onehot(head);
                        dwell_d = DWELL_W'(DWELL - 1);
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (dwell_q != '0) begin
                        dwell_d = dwell_q - DWELL_W'(1);
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        out_d   = to_onehot(head);
                        dwell_d = DWELL_W'(DWELL - 1);
                    end else begin
                        out_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    out_d   = '0;
                    dwell_d = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dwell_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: doc/onehot_decoder.md
ONEHOT_DECODER -- requirements
Module: onehot_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4: input FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter DWELL, default 4: cycles each decoded one-hot word is displayed (1..255).
REQ-003 SHALL have port clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  producer offers in_code this cycle.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a code this cycle.
REQ-007 SHALL have port in_code  input  3  binary code 0..7 to decode.
REQ-008 SHALL have port en  input  1  display enable; low pauses display.
REQ-009 SHALL have port out  output  8  registered one-hot word, bit in_code set.
REQ-010 SHALL have port out_valid  output  1  out currently holds a decoded word.
REQ-011 SHALL have port busy  output  1  FSM is in SHOW or FIFO is non-empty.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL complete an input transfer on a rising edge where in_valid and in_ready are both high; the code is written to the FIFO tail.
REQ-014 SHALL drive in_ready = (count != DEPTH), independent of a same-cycle pop; a full FIFO stalls the producer for one cycle even if a pop occurs.
REQ-015 SHALL allow simultaneous push and pop when not full; count is unchanged in that cycle.
REQ-016 SHALL hold in_code/in_valid semantics: codes are displayed in acceptance order, none dropped, none duplicated.
REQ-017 SHALL implement FSM states IDLE and SHOW.
REQ-018 IDLE: out = 8'h00, out_valid = 0; on an edge with en = 1 and count > 0, SHALL pop the head, load out = 1 << code, load dwell counter with DWELL-1, go to SHOW.
REQ-019 SHOW with en = 1 and counter > 0: SHALL decrement counter, hold out.
REQ-020 SHOW with en = 1 and counter = 0: if count > 0 SHALL pop the next code and reload out and counter in the same edge (no idle gap); otherwise SHALL go to IDLE with out = 8'h00.
REQ-021 en = 0 in any state: SHALL freeze counter, state and FIFO head; out and out_valid forced to 0 combinationally; FIFO still accepts pushes.
REQ-022 Latency: a code accepted on edge k into an empty FIFO with FSM IDLE and en = 1 SHALL appear on out after edge k+1, and stay exactly DWELL cycles.
REQ-023 out SHALL be exactly one-hot whenever out_valid = 1 and all-zero otherwise.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.

Reset
REQ-025 On an edge with rst = 1 SHALL set state IDLE, counter 0, FIFO pointers and count 0, out 8'h00, out_valid 0; in_ready = 1 after reset.
REQ-026 Reset mid-SHOW or with a non-empty FIFO SHALL discard all pending codes; a push coincident with rst SHALL be ignored.

Structure
REQ-027 SHALL place state encoding (IDLE/SHOW) and code/one-hot width constants (3, 8) in the shared package decoder_pkg.
REQ-028 SHALL implement the FIFO as one sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).
REQ-029 SHALL contain no latches; the binary-to-one-hot conversion is a combinational case inside the registered load path.

Verification
REQ-030 Reset then push code 5, en = 1 -> out = 8'h20 after edge k+1 for 4 cycles, then 8'h00, busy falls.
REQ-031 Push 0,7,3 back-to-back, DWELL = 4 -> out 8'h01, 8'h80, 8'h08 each 4 cycles, no gap, then IDLE.
REQ-032 Push 6 codes with en = 0, DEPTH = 4 -> in_ready low after 4 accepted, count = 4; raise en -> codes 1..4 shown in order, remaining 2 accepted as slots free.
REQ-033 Drop en for 3 cycles mid-SHOW of code 2 -> out = 0 during pause, then 8'h04 resumes for the remaining cycles (total display 4 enabled cycles).
REQ-034 Assert rst during SHOW with 3 codes queued -> next cycle out = 0, count = 0, in_ready = 1, no queued code ever displayed.
REQ-035 Push and pop on the same edge at count = 2 -> count stays 2; at count = 4 push is refused (in_ready = 0).
